sdram_port_arbiter: RTL and testbench

SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

---
 rtl/sdram_port_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// Four-port SDRAM burst arbiter: refresh first, then urgent ports, then
// normal requests, both request classes served round-robin. One command
// is outstanding at a time; each port walks its own frame address window.
module sdram_port_arbiter #(
  parameter int unsigned ADDR_W   = 23,
  parameter int unsigned LENGTH   = 80,
  parameter int unsigned WR1_BASE = 0,
  parameter int unsigned WR1_MAX  = 307200,
  parameter int unsigned WR2_BASE = 23'h100000,
  parameter int unsigned WR2_MAX  = 23'h100000 + 307200,
  parameter int unsigned RD1_BASE = 0,
  parameter int unsigned RD1_MAX  = 307200,
  parameter int unsigned RD2_BASE = 23'h100000,
  parameter int unsigned RD2_MAX  = 23'h100000 + 307200
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iLOAD,
  input  logic [3:0]        iREQ,
  input  logic [3:0]        iURGENT,
  input  logic              iREF_REQ,
  input  logic              iCMD_READY,
  input  logic              iDONE,
  output logic              oCMD_VALID,
  output logic              oCMD_REF,
  output logic              oCMD_WRITE,
  output logic [1:0]        oCMD_ID,
  output logic [ADDR_W-1:0] oCMD_ADDR,
  output logic              oBUSY,
  output logic [3:0]        oWRAP
);

  localparam int unsigned AW1 = ADDR_W + 1;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [AW1-1:0]    wide_t;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY} state_t;

  function automatic addr_t base_of(input logic [1:0] p);
    case (p)
      2'd0:    base_of = addr_t'(WR1_BASE);
      2'd1:    base_of = addr_t'(WR2_BASE);
      2'd2:    base_of = addr_t'(RD1_BASE);
      default: base_of = addr_t'(RD2_BASE);
    endcase
  endfunction

  function automatic wide_t max_of(input logic [1:0] p);
    case (p)
      2'd0:    max_of = wide_t'(WR1_MAX);
      2'd1:    max_of = wide_t'(WR2_MAX);
      2'd2:    max_of = wide_t'(RD1_MAX);
      default: max_of = wide_t'(RD2_MAX);
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [1:0]  rr_q, rr_d;
  addr_t       addr_q [4];
  addr_t       addr_d [4];
  logic        run_q;
  logic        valid_q, valid_d;
  logic        ref_q, ref_d;
  logic        write_q, write_d;
  logic [1:0]  id_q, id_d;
  addr_t       caddr_q, caddr_d;
  logic        busy_q, busy_d;
  logic [3:0]  wrap_q, wrap_d;

  logic [3:0]  pool;
  logic [1:0]  win;
  logic [1:0]  idx;
  logic        found;
  wide_t       sum;

  // Round-robin pick among urgent requesters, else among all requesters
  always_comb begin
    pool  = ((iREQ & iURGENT) != 4'b0000) ? (iREQ & iURGENT) : iREQ;
    win   = rr_q;
    idx   = rr_q;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = rr_q + 2'(k);
      if (!found && pool[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  // Next-state, command capture and address advance
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    ref_d   = ref_q;
    write_d = write_q;
    id_d    = id_q;
    caddr_d = caddr_q;
    busy_d  = busy_q;
    wrap_d  = 4'b0000;
    sum     = '0;

    case (state_q)
      S_IDLE: begin
        if (run_q && (iREF_REQ || (iREQ != 4'b0000))) begin
          state_d = S_ISSUE;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          if (iREF_REQ) begin
            ref_d   = 1'b1;
            write_d = 1'b0;
            id_d    = 2'd0;
            caddr_d = '0;
          end else begin
            ref_d   = 1'b0;
            write_d = ~win[1];
            id_d    = win;
            caddr_d = addr_q[win];
          end
        end
      end
      S_ISSUE: begin
        if (iCMD_READY) begin
          state_d = S_BUSY;
          valid_d = 1'b0;
        end
      end
      S_BUSY: begin
        if (iDONE) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          if (!ref_q && !iLOAD) begin
            rr_d = id_q + 2'd1;
            sum  = {1'b0, addr_q[id_q]} + wide_t'(LENGTH);
            if (sum >= max_of(id_q)) begin
              addr_d[id_q] = base_of(id_q);
              wrap_d[id_q] = 1'b1;
            end else begin
              addr_d[id_q] = sum[ADDR_W-1:0];
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Reload overrides any advance in the same cycle; FSM is left alone
    if (iLOAD) begin
      for (int p = 0; p < 4; p++) addr_d[p] = base_of(2'(p));
      rr_d = 2'd0;
    end
  end

  // State register
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Datapath and registered outputs; run_q holds off issue one cycle after reset
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      rr_q    <= 2'd0;
      for (int p = 0; p < 4; p++) addr_q[p] <= base_of(2'(p));
      run_q   <= 1'b0;
      valid_q <= 1'b0;
      ref_q   <= 1'b0;
      write_q <= 1'b0;
      id_q    <= 2'd0;
      caddr_q <= '0;
      busy_q  <= 1'b0;
      wrap_q  <= 4'b0000;
    end else begin
      rr_q    <= rr_d;
      addr_q  <= addr_d;
      run_q   <= 1'b1;
      valid_q <= valid_d;
      ref_q   <= ref_d;
      write_q <= write_d;
      id_q    <= id_d;
      caddr_q <= caddr_d;
      busy_q  <= busy_d;
      wrap_q  <= wrap_d;
    end
  end

  assign oCMD_VALID = valid_q;
  assign oCMD_REF   = ref_q;
  assign oCMD_WRITE = write_q;
  assign oCMD_ID    = id_q;
  assign oCMD_ADDR  = caddr_q;
  assign oBUSY      = busy_q;
  assign oWRAP      = wrap_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter with hand-computed expectations.
module tb_sdram_port_arbiter;

  localparam int unsigned AW = 23;
  localparam logic [AW-1:0] B0 = 23'd0;
  localparam logic [AW-1:0] B1 = 23'h100000;

  logic          iCLK = 1'b0;
  logic          iRST_N = 1'b0;
  logic          iLOAD = 1'b0;
  logic [3:0]    iREQ = 4'b0001;
  logic [3:0]    iURGENT = 4'b0000;
  logic          iREF_REQ = 1'b0;
  logic          iCMD_READY = 1'b0;
  logic          iDONE = 1'b0;
  logic          oCMD_VALID, oCMD_REF, oCMD_WRITE, oBUSY;
  logic [1:0]    oCMD_ID;
  logic [AW-1:0] oCMD_ADDR;
  logic [3:0]    oWRAP;

  int n_checks = 0;
  int n_errors = 0;

  always #5 iCLK = ~iCLK;

  sdram_port_arbiter dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iLOAD(iLOAD), .iREQ(iREQ),
    .iURGENT(iURGENT), .iREF_REQ(iREF_REQ), .iCMD_READY(iCMD_READY),
    .iDONE(iDONE), .oCMD_VALID(oCMD_VALID), .oCMD_REF(oCMD_REF),
    .oCMD_WRITE(oCMD_WRITE), .oCMD_ID(oCMD_ID), .oCMD_ADDR(oCMD_ADDR),
    .oBUSY(oBUSY), .oWRAP(oWRAP)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!oCMD_VALID && n < 50) begin
      tick();
      n++;
    end
    if (!oCMD_VALID) check({tag, "_timeout"}, 32'(oCMD_VALID), 32'd1);
  endtask

  task automatic expect_cmd(input string tag, input logic r, input logic [1:0] id,
                            input logic wr, input logic [AW-1:0] addr);
    check({tag, "_ref"},   32'(oCMD_REF),   32'(r));
    check({tag, "_id"},    32'(oCMD_ID),    32'(id));
    check({tag, "_write"}, 32'(oCMD_WRITE), 32'(wr));
    check({tag, "_addr"},  32'(oCMD_ADDR),  32'(addr));
  endtask

  task automatic accept(input bit chk);
    iCMD_READY = 1'b1;
    tick();
    iCMD_READY = 1'b0;
    if (chk) check("valid_drop", 32'(oCMD_VALID), 32'd0);
  endtask

  task automatic complete(input int dly, input logic ld, output logic [3:0] wrap);
    repeat (dly) tick();
    iDONE = 1'b1;
    iLOAD = ld;
    tick();
    iDONE = 1'b0;
    iLOAD = 1'b0;
    wrap  = oWRAP;
  endtask

  task automatic load();
    iLOAD = 1'b1;
    tick();
    iLOAD = 1'b0;
  endtask

  initial begin
    logic [3:0]      w;
    logic [1:0]      ids [5]   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [AW-1:0]   adrs [5]  = '{B0, B1, B0, B1, 23'd80};
    logic [AW+7:0]   snap;
    int              wraps, wrap_at;
    logic [3:0]      wrap_val;

    // Reset state
    repeat (2) tick();
    check("rst_valid", 32'(oCMD_VALID), 32'd0);
    check("rst_busy",  32'(oBUSY),      32'd0);
    check("rst_id",    32'(oCMD_ID),    32'd0);
    check("rst_addr",  32'(oCMD_ADDR),  32'd0);
    check("rst_wrap",  32'(oWRAP),      32'd0);

    // Release with a request pending: no issue on the first edge
    iRST_N = 1'b1;
    tick();
    check("rel_edge1_valid", 32'(oCMD_VALID), 32'd0);
    tick();
    check("rel_edge2_valid", 32'(oCMD_VALID), 32'd1);
    expect_cmd("rel", 1'b0, 2'd0, 1'b1, B0);
    iREQ = 4'b0000;
    accept(1);
    complete(2, 1'b0, w);
    tick();
    check("idle_busy", 32'(oBUSY), 32'd0);
    load();

    // Round robin over all four ports
    iREQ = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_valid("rr");
      expect_cmd($sformatf("rr%0d", i), 1'b0, ids[i], ~ids[i][1], adrs[i]);
      check("rr_busy", 32'(oBUSY), 32'd1);
      accept(1);
      complete(2, 1'b0, w);
    end
    iREQ = 4'b0000;
    tick();
    load();

    // Urgent port beats round robin
    iREQ = 4'b1111;
    iURGENT = 4'b0100;
    wait_valid("urg");
    expect_cmd("urg", 1'b0, 2'd2, 1'b0, B0);
    iREQ = 4'b0000;
    iURGENT = 4'b0000;
    accept(1);
    complete(2, 1'b0, w);

    // Refresh first, then port 0; RR now 3
    iREF_REQ = 1'b1;
    iREQ = 4'b0001;
    wait_valid("ref1");
    expect_cmd("ref1", 1'b1, 2'd0, 1'b0, B0);
    iREF_REQ = 1'b0;
    accept(1);
    complete(2, 1'b0, w);
    wait_valid("ref1p0");
    expect_cmd("ref1p0", 1'b0, 2'd0, 1'b1, B0);
    iREQ = 4'b0000;
    accept(1);
    complete(2, 1'b0, w);

    // RR is 1 now; a refresh in between must not move it
    iREF_REQ = 1'b1;
    iREQ = 4'b1111;
    wait_valid("ref2");
    expect_cmd("ref2", 1'b1, 2'd0, 1'b0, B0);
    iREF_REQ = 1'b0;
    accept(1);
    complete(2, 1'b0, w);
    wait_valid("ref2p1");
    expect_cmd("ref2p1", 1'b0, 2'd1, 1'b1, B1);
    iREQ = 4'b0000;
    accept(1);
    complete(2, 1'b0, w);
    tick();
    load();

    // Stall in ISSUE: outputs hold, stray iDONE and input changes ignored
    iREQ = 4'b0100;
    wait_valid("stall");
    expect_cmd("stall", 1'b0, 2'd2, 1'b0, B0);
    snap = {oCMD_VALID, oCMD_REF, oCMD_WRITE, oCMD_ID, oBUSY, oCMD_ADDR, 2'b00};
    iREQ = 4'b1000;
    iURGENT = 4'b1000;
    for (int c = 0; c < 5; c++) begin
      iDONE = (c == 2);
      tick();
      iDONE = 1'b0;
      check($sformatf("stall_hold%0d", c),
            32'({oCMD_VALID, oCMD_REF, oCMD_WRITE, oCMD_ID, oBUSY, oCMD_ADDR, 2'b00}),
            32'(snap));
    end
    iREQ = 4'b0000;
    iURGENT = 4'b0000;
    accept(1);
    complete(2, 1'b0, w);
    tick();
    load();

    // Port 1 frame wrap after 3840 bursts
    iREQ = 4'b0010;
    wraps = 0;
    wrap_at = 0;
    wrap_val = 4'b0000;
    for (int i = 1; i <= 3840; i++) begin
      wait_valid("wrap");
      accept(0);
      complete(0, 1'b0, w);
      if (w != 4'b0000) begin
        wraps++;
        wrap_at = i;
        wrap_val = w;
      end
    end
    check("wrap_count", 32'(wraps), 32'd1);
    check("wrap_at", 32'(wrap_at), 32'd3840);
    check("wrap_bits", 32'(wrap_val), 32'b0010);
    tick();
    check("wrap_pulse_end", 32'(oWRAP), 32'd0);
    wait_valid("wrap_after");
    expect_cmd("wrap_after", 1'b0, 2'd1, 1'b1, B1);
    iREQ = 4'b0000;
    accept(1);
    complete(1, 1'b0, w);
    tick();
    load();

    // Walk port 0 to 307120, then reload coincides with its iDONE
    iREQ = 4'b0001;
    for (int i = 0; i < 3839; i++) begin
      wait_valid("walk");
      accept(0);
      complete(0, 1'b0, w);
    end
    wait_valid("last");
    expect_cmd("last", 1'b0, 2'd0, 1'b1, 23'd307120);
    iREQ = 4'b1111;
    accept(1);
    complete(1, 1'b1, w);
    check("load_done_wrap", 32'(w), 32'd0);
    wait_valid("postload");
    expect_cmd("postload", 1'b0, 2'd0, 1'b1, B0);
    iREQ = 4'b1000;
    accept(1);
    complete(1, 1'b0, w);
    wait_valid("p3");
    expect_cmd("p3", 1'b0, 2'd3, 1'b0, B1);
    iREQ = 4'b0000;
    accept(1);
    check("p3_busy", 32'(oBUSY), 32'd1);

    // Asynchronous reset in BUSY clears outputs without a clock edge
    iRST_N = 1'b0;
    #1;
    check("arst_busy",  32'(oBUSY),      32'd0);
    check("arst_valid", 32'(oCMD_VALID), 32'd0);
    check("arst_id",    32'(oCMD_ID),    32'd0);
    check("arst_addr",  32'(oCMD_ADDR),  32'd0);
    check("arst_write", 32'(oCMD_WRITE), 32'd0);
    check("arst_ref",   32'(oCMD_REF),   32'd0);
    check("arst_wrap",  32'(oWRAP),      32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
